// File: rtl/crossing_arbiter_if.sv
// Handshake bundle between the track request logic and the crossing arbiter.
// The master drives the train requests; the slave drives the lights, gate and grants.
interface crossing_arbiter_if;
  logic       req_a;
  logic       req_b;
  logic [1:0] road;
  logic [1:0] track_a;
  logic [1:0] track_b;
  logic       gate_down;
  logic       grant_a;
  logic       grant_b;

  modport master (
    output req_a, req_b,
    input  road, track_a, track_b, gate_down, grant_a, grant_b
  );

  modport slave (
    input  req_a, req_b,
    output road, track_a, track_b, gate_down, grant_a, grant_b
  );
endinterface

// File: rtl/crossing_arbiter.sv
// Round-robin arbiter sharing one level crossing between tracks A and B.
// Sequences the road light, both track signals and the gate so that only one track is released.
//
// state        | meaning
// S_ROAD       | road green, both tracks red, gate up
// S_ROAD_WARN  | road yellow before a track is granted (arbitration on last cycle)
// S_TRACK      | owner track green, road red, gate down
// S_TRACK_WARN | owner track yellow; hands over, re-grants or returns to road
module crossing_arbiter #(
  parameter int YELLOW_CYCLES  = 2,
  parameter int MIN_ROAD_GREEN = 4
) (
  input  logic                 clk,
  input  logic                 clr_n,
  crossing_arbiter_if.slave    bus
);

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam int CMAX = (YELLOW_CYCLES > MIN_ROAD_GREEN) ? YELLOW_CYCLES : MIN_ROAD_GREEN;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] GREEN_LAST  = CW'(MIN_ROAD_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT     = {CW{1'b1}};

  typedef enum logic [1:0] {S_ROAD, S_ROAD_WARN, S_TRACK, S_TRACK_WARN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;    // 0 = A, 1 = B
  logic          owner, owner_nxt;  // 0 = A, 1 = B
  logic          own_req, oth_req;
  logic [1:0]    road_nxt, track_a_nxt, track_b_nxt, owner_col;
  logic          gate_nxt, grant_a_nxt, grant_b_nxt, held;

  assign own_req = owner ? bus.req_b : bus.req_a;
  assign oth_req = owner ? bus.req_a : bus.req_b;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    case (state)
      S_ROAD: begin
        if ((bus.req_a || bus.req_b) && cnt >= GREEN_LAST) state_nxt = S_ROAD_WARN;
      end
      S_ROAD_WARN: begin
        if (cnt >= YELLOW_LAST) begin
          if (!bus.req_a && !bus.req_b) begin
            state_nxt = S_ROAD;
          end else begin
            state_nxt = S_TRACK;
            if (bus.req_a && bus.req_b) owner_nxt = ~last;
            else                        owner_nxt = bus.req_b;
            last_nxt = owner_nxt;
          end
        end
      end
      S_TRACK: begin
        if (!own_req) state_nxt = S_TRACK_WARN;
      end
      S_TRACK_WARN: begin
        if (cnt >= YELLOW_LAST) begin
          if (oth_req) begin
            state_nxt = S_TRACK;
            owner_nxt = ~owner;
            last_nxt  = ~owner;
          end else if (own_req) begin
            state_nxt = S_TRACK;
          end else begin
            state_nxt = S_ROAD;
          end
        end
      end
      default: state_nxt = S_ROAD;
    endcase

    // Every state entry is a state change, so a change restarts the phase timer.
    if (state_nxt != state)  cnt_nxt = '0;
    else if (cnt == CNT_SAT) cnt_nxt = cnt;
    else                     cnt_nxt = cnt + 1'b1;
  end

  // Outputs are derived from the next state so the registers track the state with no lag.
  always_comb begin
    held        = (state_nxt == S_TRACK) || (state_nxt == S_TRACK_WARN);
    owner_col   = (state_nxt == S_TRACK) ? GREEN : YELLOW;
    road_nxt    = (state_nxt == S_ROAD) ? GREEN : (state_nxt == S_ROAD_WARN) ? YELLOW : RED;
    track_a_nxt = (held && !owner_nxt) ? owner_col : RED;
    track_b_nxt = (held &&  owner_nxt) ? owner_col : RED;
    gate_nxt    = held;
    grant_a_nxt = held && !owner_nxt;
    grant_b_nxt = held &&  owner_nxt;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state         <= S_ROAD;
      cnt           <= '0;
      last          <= 1'b1;
      owner         <= 1'b0;
      bus.road      <= GREEN;
      bus.track_a   <= RED;
      bus.track_b   <= RED;
      bus.gate_down <= 1'b0;
      bus.grant_a   <= 1'b0;
      bus.grant_b   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      last          <= last_nxt;
      owner         <= owner_nxt;
      bus.road      <= road_nxt;
      bus.track_a   <= track_a_nxt;
      bus.track_b   <= track_b_nxt;
      bus.gate_down <= gate_nxt;
      bus.grant_a   <= grant_a_nxt;
      bus.grant_b   <= grant_b_nxt;
    end
  end

endmodule

// File: tb/tb_crossing_arbiter.sv
// Bench for crossing_arbiter: directed scenarios plus random traffic on three parameter sets,
// every cycle checked against a phase/elapsed-time model of the crossing rules.
module tb_crossing_arbiter;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  localparam int P_GO = 0, P_GO_WARN = 1, P_HOLD = 2, P_HOLD_WARN = 3;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  crossing_arbiter_if if0 ();
  crossing_arbiter_if if1 ();
  crossing_arbiter_if if2 ();

  crossing_arbiter u0 (.clk(clk), .clr_n(clr_n), .bus(if0));
  crossing_arbiter #(.YELLOW_CYCLES(1), .MIN_ROAD_GREEN(1)) u1 (.clk(clk), .clr_n(clr_n), .bus(if1));
  crossing_arbiter #(.YELLOW_CYCLES(5), .MIN_ROAD_GREEN(7)) u2 (.clk(clk), .clr_n(clr_n), .bus(if2));

  int vectors = 0;
  int miscompares = 0;

  int yc [3] = '{2, 1, 5};
  int mg [3] = '{4, 1, 7};
  int ph [3];
  int el [3];   // cycles spent in current phase, including the present one
  int own [3];
  int lst [3];
  int ra_s [3];
  int rb_s [3];
  bit rand0 = 1'b0;

  task automatic cmp(input string tag, input int i, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s inst%0d observed=%0d expected=%0d", tag, i, obs, exp);
    end
  endtask

  task automatic model_step(input int i, input int ra, input int rb, input bit rst_ok);
    int np, no, mine, other;
    if (!rst_ok) begin
      ph[i] = P_GO; el[i] = 1; lst[i] = 1; own[i] = 0;
      return;
    end
    np = ph[i]; no = own[i];
    mine  = own[i] ? rb : ra;
    other = own[i] ? ra : rb;
    case (ph[i])
      P_GO:      if ((ra || rb) && el[i] >= mg[i]) np = P_GO_WARN;
      P_GO_WARN: if (el[i] == yc[i]) begin
                   if (ra && rb) no = 1 - lst[i];
                   else if (ra)  no = 0;
                   else if (rb)  no = 1;
                   if (!ra && !rb) np = P_GO;
                   else begin np = P_HOLD; lst[i] = no; end
                 end
      P_HOLD:    if (!mine) np = P_HOLD_WARN;
      default:   if (el[i] == yc[i]) begin
                   if (other) begin np = P_HOLD; no = 1 - own[i]; lst[i] = no; end
                   else if (mine) np = P_HOLD;
                   else np = P_GO;
                 end
    endcase
    el[i]  = (np != ph[i]) ? 1 : el[i] + 1;
    ph[i]  = np;
    own[i] = no;
  endtask

  task automatic check_inst(input int i, input logic [1:0] rd, input logic [1:0] ta,
                            input logic [1:0] tb, input logic gd, input logic ga, input logic gb);
    int held, e_rd, e_oc;
    held = (ph[i] == P_HOLD) || (ph[i] == P_HOLD_WARN);
    e_rd = (ph[i] == P_GO) ? GREEN : (ph[i] == P_GO_WARN) ? YELLOW : RED;
    e_oc = (ph[i] == P_HOLD) ? GREEN : YELLOW;
    cmp("road",      i, rd, e_rd);
    cmp("track_a",   i, ta, (held && own[i] == 0) ? e_oc : RED);
    cmp("track_b",   i, tb, (held && own[i] == 1) ? e_oc : RED);
    cmp("gate_down", i, gd, held);
    cmp("grant_a",   i, ga, held && own[i] == 0);
    cmp("grant_b",   i, gb, held && own[i] == 1);
    cmp("inv_green_tracks_red", i, (rd == GREEN) && (ta != RED || tb != RED), 0);
    cmp("inv_one_track",        i, (ta != RED) && (tb != RED), 0);
    cmp("inv_gate_road",        i, gd, rd == RED);
    cmp("inv_one_grant",        i, ga && gb, 0);
  endtask

  // Random requests change rarely so trains hold the crossing for a while.
  function automatic int wander(input int v);
    return ($urandom_range(0, 7) == 0) ? 1 - v : v;
  endfunction

  task automatic tick(input bit rst_ok, input int ra0, input int rb0);
    clr_n = rst_ok;
    if (rand0) begin ra_s[0] = wander(ra_s[0]); rb_s[0] = wander(rb_s[0]); end
    else begin ra_s[0] = ra0; rb_s[0] = rb0; end
    for (int i = 1; i < 3; i++) begin ra_s[i] = wander(ra_s[i]); rb_s[i] = wander(rb_s[i]); end
    if0.req_a = ra_s[0][0]; if0.req_b = rb_s[0][0];
    if1.req_a = ra_s[1][0]; if1.req_b = rb_s[1][0];
    if2.req_a = ra_s[2][0]; if2.req_b = rb_s[2][0];
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, ra_s[i], rb_s[i], rst_ok);
    #1;
    check_inst(0, if0.road, if0.track_a, if0.track_b, if0.gate_down, if0.grant_a, if0.grant_b);
    check_inst(1, if1.road, if1.track_a, if1.track_b, if1.gate_down, if1.grant_a, if1.grant_b);
    check_inst(2, if2.road, if2.track_a, if2.track_b, if2.gate_down, if2.grant_a, if2.grant_b);
  endtask

  initial begin
    clr_n = 1'b0;
    for (int i = 0; i < 3; i++) begin ra_s[i] = 0; rb_s[i] = 0; end
    if0.req_a = 0; if0.req_b = 0; if1.req_a = 0; if1.req_b = 0; if2.req_a = 0; if2.req_b = 0;

    // 1: reset then req_a; road green through E3, yellow E4-E5, A granted from E6
    tick(0, 0, 0); tick(0, 0, 0);
    cmp("t1_reset_road", 0, if0.road, GREEN);
    cmp("t1_reset_gate", 0, if0.gate_down, 0);
    for (int n = 1; n <= 6; n++) begin
      tick(1, 1, 0);
      cmp("t1_road_seq", 0, if0.road, (n <= 3) ? GREEN : (n <= 5) ? YELLOW : RED);
    end
    cmp("t1_grant_a", 0, if0.grant_a, 1);
    cmp("t1_track_a", 0, if0.track_a, GREEN);
    tick(1, 1, 0);

    // 2: release A, road returns, B waits full min-green
    tick(1, 0, 0); cmp("t2_a_yellow", 0, if0.track_a, YELLOW);
    tick(1, 0, 0); cmp("t2_a_yellow2", 0, if0.track_a, YELLOW);
    tick(1, 0, 0); cmp("t2_road_back", 0, if0.road, GREEN);
    for (int n = 4; n <= 9; n++) begin
      tick(1, 0, 1);
      cmp("t2_seq", 0, if0.road, (n <= 6) ? GREEN : (n <= 8) ? YELLOW : RED);
    end
    cmp("t2_track_b", 0, if0.track_b, GREEN);

    // 3: simultaneous requests, A first, direct hand-over to B, then back to A
    tick(0, 0, 0);
    for (int n = 0; n < 6; n++) tick(1, 1, 1);
    cmp("t3_a_first", 0, if0.grant_a, 1);
    for (int n = 0; n < 3; n++) begin
      tick(1, 0, 1);
      cmp("t3_road_red", 0, if0.road, RED);
    end
    cmp("t3_b_green", 0, if0.track_b, GREEN);
    for (int n = 0; n < 3; n++) begin
      tick(1, 1, 0);
      cmp("t3_road_red2", 0, if0.road, RED);
    end
    cmp("t3_a_regrant", 0, if0.grant_a, 1);

    // 4: request withdrawn during road yellow
    tick(0, 0, 0);
    for (int n = 0; n < 5; n++) tick(1, 1, 0);
    cmp("t4_yellow", 0, if0.road, YELLOW);
    tick(1, 0, 0);
    cmp("t4_back_green", 0, if0.road, GREEN);
    cmp("t4_no_grant", 0, if0.grant_a, 0);
    for (int n = 1; n <= 4; n++) begin
      tick(1, 1, 0);
      cmp("t4_full_green", 0, if0.road, (n <= 3) ? GREEN : YELLOW);
    end

    // 5: reset while A holds the crossing
    for (int n = 0; n < 4; n++) tick(1, 1, 0);
    cmp("t5_held", 0, if0.grant_a, 1);
    tick(0, 1, 0);
    cmp("t5_rst_road", 0, if0.road, GREEN);
    cmp("t5_rst_gate", 0, if0.gate_down, 0);
    cmp("t5_rst_grant", 0, if0.grant_a, 0);
    for (int n = 0; n < 6; n++) tick(1, 1, 0);
    cmp("t5_restart", 0, if0.grant_a, 1);

    // 6: random traffic on all parameter sets
    rand0 = 1'b1;
    for (int n = 0; n < 10000; n++) tick(1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
